// File: rtl/rr_mux_nx1_pkg.sv
// Shared definitions for the rr_mux_nx1 stream merger and its arbiter.
// Holds the arbitration mode constants and the pointer-advance helper.
package rr_mux_nx1_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Next round-robin start index; wraps explicitly so non power-of-two N never hits an unused slot.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_nx1_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed priority (index 0 highest).
// Reusable by any block that needs a single grant out of a request vector.
module rr_arbiter
  import rr_mux_nx1_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  localparam logic [SEL_W:0] NumCh = (SEL_W + 1)'(N);

  logic [SEL_W-1:0] start;
  logic [SEL_W:0]   probe;
  logic [SEL_W-1:0] idx;

  // Walk the requests starting at 'start', wrapping at N-1; the first hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    probe      = '0;
    idx        = '0;
    start      = (mode == ARB_FIXED) ? '0 : ptr;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, start} + (SEL_W + 1)'(k);
      if (probe >= NumCh) probe = probe - NumCh;
      idx = probe[SEL_W-1:0];
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// Registered N:1 stream merger with valid/ready on every channel.
// Channel choice comes from rr_arbiter; the output register accepts a word whenever it is empty or being drained.
module rr_mux_nx1
  import rr_mux_nx1_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_RR,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  localparam arb_mode_e ArbMode = (MODE == MODE_FIXED) ? ARB_FIXED : ARB_RR;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             load;
  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .req        (in_valid),
    .ptr        (ptr_q),
    .mode       (ArbMode),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign load     = !valid_q || out_ready;
  assign in_ready = load ? gnt_onehot : '0;

  // A stalled output holds everything; an idle load only drops valid.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (load) begin
      if (gnt_any) begin
        data_d  = ch_data[gnt_idx];
        sel_d   = gnt_idx;
        valid_d = 1'b1;
        ptr_d   = SEL_W'(wrap_inc(int'(gnt_idx), N));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: doc/rr_mux_nx1.md
Name: rr_mux_nx1

Overview:
- Parametrised, registered successor to the library's combinational 4:1 mux: N input channels of WIDTH bits, each with a valid/ready handshake, merged onto one registered output channel.
- Selection is by a round-robin arbiter, or by fixed priority when MODE selects it; the select lines are internal, not driven by the user.
- Sits in the combinational_circuits/sequential boundary of the library as the general-purpose N:1 stream merger.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (channel 0 highest).
- SEL_W, $clog2(N), width of the channel index (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_sel  output  SEL_W  index of the channel that supplied the current out_data.

Behaviour:
- Reset is asynchronous and active-high. On rst high, clear out_valid=0, out_data=0, out_sel=0 and rr pointer ptr=0. A reset mid-transfer drops any held word.
- load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant, MODE=0: the first asserted in_valid at or after index ptr, searching upward with wrap N-1 -> 0.
- Grant, MODE=1: the lowest asserted in_valid index. ptr is still maintained but ignored.
- in_ready[g] = load && in_valid[g] for the granted g only. All other bits are 0, and all bits are 0 when no in_valid is set. in_ready is combinational from in_valid, out_valid and out_ready.
- On a transfer (load && any in_valid), at the rising edge: out_data<=in_data[g]; out_sel<=g; out_valid<=1; ptr<=(g==N-1)?0:g+1.
- When load=1 and no in_valid is set: out_valid<=0; out_data, out_sel and ptr hold.
- When out_valid=1 and out_ready=0 (stall): out_data, out_sel, out_valid and ptr hold, and all in_ready=0.
- Latency is 1 cycle from input handshake to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous pop and push: out_ready=1 with out_valid=1 and some in_valid set replaces the word in the same edge, with no bubble.
- Fairness, MODE=0: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- N not a power of two: ptr wraps explicitly at N-1 and never reaches an unused index.
- Input data is not required to be stable before its handshake. Only the granted word at the handshake edge is captured.

Decomposition:
- Shared include file (library header): MODE_RR=0, MODE_FIXED=1 constants; a clog2 helper if the toolchain lacks $clog2.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req[N], ptr[SEL_W], mode.
  - Outputs: gnt_onehot[N], gnt_idx[SEL_W], any.
- The top level holds ptr, the output register and the handshake logic.
- rr_arbiter is reusable by later library blocks (bus arbiters, request mergers).

Test Plan:
- Reset: assert rst asynchronously mid-cycle while out_valid=1. Required: out_valid=0, out_data=0, out_sel=0 immediately, without waiting for a clock edge; the next grant after release comes from channel 0.
- Round-robin sweep, N=4, WIDTH=8, MODE=0, in_data = {8'h33,8'h22,8'h11,8'h00}, in_valid=4'b1111, out_ready=1. Required: out_sel sequence 0,1,2,3,0 and out_data 00,11,22,33,00 on consecutive cycles.
- Skip idle channels: in_valid=4'b1010, ptr=0. Required: grants go to 1, then 3, then 1. in_ready alternates 4'b0010 and 4'b1000.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and out_data=8'h22. Required: out_data and out_sel hold, in_ready=4'b0000 throughout. When out_ready rises, the next word loads on that edge with no bubble cycle.
- Fixed priority, MODE=1: in_valid=4'b1100, then 4'b1101. Required: grant 2 while in_valid=4'b1100; grant 0 on the first cycle bit 0 is set; channel 3 is starved while a lower channel stays valid.
- Empty drain: in_valid=0 with out_ready=1 after one word. Required: out_valid falls to 0 on the next edge, and out_data keeps its last value.
